// File: rtl/vp_ps2_key_rx.sv
// Host-side PS/2 keyboard receiver: synchronise, filter, deserialise, fold E0/F0 prefixes into an 11-bit event word.
// Optional macro VP_PS2_TYPEMATIC_FILTER_EN suppresses typematic repeats of the currently held key.
module vp_ps2_key_rx #(
    parameter int FILT_LEN    = 8,
    parameter int TIMEOUT_CYC = 150000
) (
    input  logic        clk_sys,
    input  logic        res_n_i,
    input  logic        ps2_clk_i,
    input  logic        ps2_dat_i,
    output logic [10:0] ps2_key_o,
    output logic        err_o
);

    // state  | meaning
    // IDLE   | waiting for a start bit
    // DATA   | shifting in 8 data bits, LSB first
    // PARITY | sampling the odd-parity bit
    // STOP   | sampling the stop bit, accept or flag the byte
    typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;

    localparam int FW = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;
    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    logic [1:0]    r_sync1, r_sync2, r_filt;
    logic [FW-1:0] r_fcnt [2];
    logic          r_clk_d, r_sample, r_dat_smp;
    state_t        r_state, w_state_nxt;
    logic [7:0]    r_shift, r_byte;
    logic [2:0]    r_bitcnt;
    logic          r_par_ok, r_byte_vld;
    logic [TW-1:0] r_tmo_cnt;
    logic          r_ext, r_brk, r_err;
    logic [10:0]   r_key;
    logic          w_tmo, w_frm_err, w_accept, w_suppress;
    logic [8:0]    w_code;
    logic [1:0]    w_raw;

    assign w_raw     = {ps2_dat_i, ps2_clk_i};
    assign w_code    = {r_ext, r_byte};
    assign ps2_key_o = r_key;
    assign err_o     = r_err;

    // Index 0 is the PS/2 clock, index 1 is the data line.
    always_ff @(posedge clk_sys or negedge res_n_i) begin
        if (!res_n_i) begin
            r_sync1   <= 2'b11;
            r_sync2   <= 2'b11;
            r_filt    <= 2'b11;
            r_fcnt[0] <= '0;
            r_fcnt[1] <= '0;
            r_clk_d   <= 1'b1;
            r_sample  <= 1'b0;
            r_dat_smp <= 1'b1;
        end else begin
            r_sync1 <= w_raw;
            r_sync2 <= r_sync1;
            for (int i = 0; i < 2; i++) begin
                if (r_sync2[i] != r_filt[i]) begin
                    if (r_fcnt[i] == FW'(FILT_LEN - 1)) begin
                        r_filt[i] <= r_sync2[i];
                        r_fcnt[i] <= '0;
                    end else begin
                        r_fcnt[i] <= r_fcnt[i] + 1'b1;
                    end
                end else begin
                    r_fcnt[i] <= '0;
                end
            end
            r_clk_d   <= r_filt[0];
            r_sample  <= r_clk_d & ~r_filt[0];
            r_dat_smp <= r_filt[1];
        end
    end

    // A sample point always takes priority over a timeout in the same cycle.
    always_comb begin
        w_state_nxt = r_state;
        w_tmo       = 1'b0;
        w_frm_err   = 1'b0;
        w_accept    = 1'b0;
        if (r_sample) begin
            case (r_state)
                S_IDLE:   if (!r_dat_smp) w_state_nxt = S_DATA;
                S_DATA:   if (r_bitcnt == 3'd7) w_state_nxt = S_PARITY;
                S_PARITY: w_state_nxt = S_STOP;
                S_STOP: begin
                    w_state_nxt = S_IDLE;
                    if (r_par_ok && r_dat_smp) w_accept  = 1'b1;
                    else                       w_frm_err = 1'b1;
                end
                default:  w_state_nxt = S_IDLE;
            endcase
        end else if (r_state != S_IDLE && r_tmo_cnt == TW'(TIMEOUT_CYC)) begin
            w_state_nxt = S_IDLE;
            w_tmo       = 1'b1;
        end
    end

    always_ff @(posedge clk_sys or negedge res_n_i) begin
        if (!res_n_i) begin
            r_state    <= S_IDLE;
            r_shift    <= '0;
            r_bitcnt   <= '0;
            r_par_ok   <= 1'b0;
            r_tmo_cnt  <= '0;
            r_byte     <= '0;
            r_byte_vld <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_err      <= w_frm_err | w_tmo;
            r_byte_vld <= w_accept;
            if (w_accept) r_byte <= r_shift;
            if (r_sample && r_state == S_DATA) begin
                r_shift  <= {r_dat_smp, r_shift[7:1]};
                r_bitcnt <= r_bitcnt + 1'b1;
            end else if (w_tmo) begin
                r_bitcnt <= '0;
            end
            if (r_sample && r_state == S_PARITY) r_par_ok <= ^{r_shift, r_dat_smp};
            if (r_state == S_IDLE || r_sample || w_tmo) r_tmo_cnt <= '0;
            else                                        r_tmo_cnt <= r_tmo_cnt + 1'b1;
        end
    end

`ifdef VP_PS2_TYPEMATIC_FILTER_EN
    logic [8:0] r_held;
    logic       r_held_vld;

    assign w_suppress = ~r_brk & r_held_vld & (r_held == w_code);

    always_ff @(posedge clk_sys or negedge res_n_i) begin
        if (!res_n_i) begin
            r_held     <= '0;
            r_held_vld <= 1'b0;
        end else if (r_byte_vld) begin
            case (r_byte)
                8'hE0, 8'hF0, 8'hE1, 8'hAA, 8'hFA, 8'hFE, 8'h00, 8'hFF: ;
                default: begin
                    if (!r_brk) begin
                        r_held     <= w_code;
                        r_held_vld <= 1'b1;
                    end else if (r_held == w_code) begin
                        r_held_vld <= 1'b0;
                    end
                end
            endcase
        end
    end
`else
    assign w_suppress = 1'b0;
`endif

    always_ff @(posedge clk_sys or negedge res_n_i) begin
        if (!res_n_i) begin
            r_key <= '0;
            r_ext <= 1'b0;
            r_brk <= 1'b0;
        end else if (r_byte_vld) begin
            case (r_byte)
                8'hE0: r_ext <= 1'b1;
                8'hF0: r_brk <= 1'b1;
                8'hE1, 8'hAA, 8'hFA, 8'hFE, 8'h00, 8'hFF: ;
                default: begin
                    if (!w_suppress) r_key <= {~r_key[10], ~r_brk, w_code};
                    r_ext <= 1'b0;
                    r_brk <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vp_ps2_key_rx.sv
// Self-checking bench for vp_ps2_key_rx: directed scenarios plus random frames against a byte-level event model.
module tb_vp_ps2_key_rx;

    localparam int FILT_LEN    = 4;
    localparam int TIMEOUT_CYC = 2000;
    localparam int HALF        = 40;

    logic        clk_sys = 1'b0;
    logic        res_n   = 1'b0;
    logic        ps2_clk = 1'b1;
    logic        ps2_dat = 1'b1;
    logic [10:0] ps2_key;
    logic        err;

    int checks = 0, failures = 0;
    int err_seen = 0, tog_seen = 0;
    int m_err = 0, m_tog = 0;
    logic        prev_t = 1'b0;
    logic [10:0] m_key = '0;
    logic        m_ext = 1'b0, m_brk = 1'b0;
    logic [8:0]  m_held = '0;
    logic        m_held_vld = 1'b0;

    vp_ps2_key_rx #(.FILT_LEN(FILT_LEN), .TIMEOUT_CYC(TIMEOUT_CYC)) dut (
        .clk_sys  (clk_sys),
        .res_n_i  (res_n),
        .ps2_clk_i(ps2_clk),
        .ps2_dat_i(ps2_dat),
        .ps2_key_o(ps2_key),
        .err_o    (err)
    );

    always #5 clk_sys = ~clk_sys;

    always @(negedge clk_sys) begin
        if (res_n) begin
            if (err) err_seen++;
            if (ps2_key[10] !== prev_t) tog_seen++;
        end
        prev_t = ps2_key[10];
    end

    task automatic model_reset();
        m_key = '0; m_ext = 1'b0; m_brk = 1'b0; m_held_vld = 1'b0;
    endtask

    task automatic model_byte(input logic [7:0] b);
        logic sup;
        sup = 1'b0;
        if (b == 8'hE0) m_ext = 1'b1;
        else if (b == 8'hF0) m_brk = 1'b1;
        else if (!(b inside {8'hE1, 8'hAA, 8'hFA, 8'hFE, 8'h00, 8'hFF})) begin
`ifdef VP_PS2_TYPEMATIC_FILTER_EN
            if (!m_brk && m_held_vld && m_held == {m_ext, b}) sup = 1'b1;
            else if (!m_brk) begin m_held = {m_ext, b}; m_held_vld = 1'b1; end
            else if (m_held == {m_ext, b}) m_held_vld = 1'b0;
`endif
            if (!sup) begin
                m_key = {~m_key[10], ~m_brk, m_ext, b};
                m_tog++;
            end
            m_ext = 1'b0;
            m_brk = 1'b0;
        end
    endtask

    task automatic ps2_bit(input logic b, input bit glitch);
        @(negedge clk_sys);
        ps2_dat = b;
        repeat (HALF / 2) @(negedge clk_sys);
        if (glitch) begin
            ps2_clk = 1'b0;
            repeat (FILT_LEN - 2) @(negedge clk_sys);
            ps2_clk = 1'b1;
        end
        repeat (HALF / 2) @(negedge clk_sys);
        ps2_clk = 1'b0;
        repeat (HALF) @(negedge clk_sys);
        ps2_clk = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b, input bit bad_par, input int nbits, input bit glitch);
        logic [10:0] f;
        f = {1'b1, ~(^b) ^ bad_par, b, 1'b0};
        for (int i = 0; i < nbits; i++) ps2_bit(f[i], glitch);
        @(negedge clk_sys);
        ps2_dat = 1'b1;
        repeat (HALF) @(negedge clk_sys);
    endtask

    task automatic send_good(input logic [7:0] b);
        send_frame(b, 1'b0, 11, 1'b0);
        model_byte(b);
    endtask

    task automatic check_state(input string name);
        checks++;
        if (ps2_key !== m_key) begin
            failures++;
            $display("FAIL %s key: got %h expected %h", name, ps2_key, m_key);
        end
        checks++;
        if (tog_seen !== m_tog || err_seen !== m_err) begin
            failures++;
            $display("FAIL %s counts: toggles %0d/%0d errors %0d/%0d (got/expected)", name, tog_seen, m_tog, err_seen, m_err);
        end
    endtask

    task automatic test_reset();
        res_n = 1'b0;
        repeat (5) @(negedge clk_sys);
        checks++;
        if (ps2_key !== 11'h000 || err !== 1'b0) begin
            failures++;
            $display("FAIL reset: key %h err %b, expected 000 0", ps2_key, err);
        end
        res_n = 1'b1;
        repeat (20) @(negedge clk_sys);
        check_state("reset_idle");
    endtask

    task automatic test_press_release();
        send_good(8'h16);
        checks++;
        if (ps2_key !== 11'h616) begin
            failures++;
            $display("FAIL make_16: got %h expected 616", ps2_key);
        end
        check_state("make_16");
        send_good(8'hF0);
        send_good(8'h16);
        checks++;
        if (ps2_key[9:0] !== 10'h016) begin
            failures++;
            $display("FAIL break_16: got %h expected 016", ps2_key[9:0]);
        end
        check_state("break_16");
    endtask

    task automatic test_latency();
        logic [10:0] f;
        logic        t0;
        int          n;
        f  = {1'b1, ~(^8'h33), 8'h33, 1'b0};
        for (int i = 0; i < 10; i++) ps2_bit(f[i], 1'b0);
        @(negedge clk_sys);
        ps2_dat = 1'b1;
        repeat (HALF) @(negedge clk_sys);
        t0 = ps2_key[10];
        ps2_clk = 1'b0;
        n = 0;
        while (ps2_key[10] === t0 && n < 60) begin
            @(posedge clk_sys);
            #1;
            n++;
        end
        checks++;
        if (n !== 2 + FILT_LEN + 1 + 2) begin
            failures++;
            $display("FAIL latency: got %0d cycles expected %0d", n, 2 + FILT_LEN + 1 + 2);
        end
        repeat (HALF) @(negedge clk_sys);
        ps2_clk = 1'b1;
        repeat (HALF) @(negedge clk_sys);
        model_byte(8'h33);
        check_state("latency_33");
    endtask

    task automatic test_ext_break();
        send_good(8'hE0);
        send_good(8'hF0);
        send_good(8'h75);
        checks++;
        if (ps2_key[9:0] !== 10'h175) begin
            failures++;
            $display("FAIL ext_break: got %h expected 175", ps2_key[9:0]);
        end
        check_state("ext_break");
        send_good(8'h1C);
        checks++;
        if (ps2_key[9:0] !== 10'h21C) begin
            failures++;
            $display("FAIL flags_cleared: got %h expected 21C", ps2_key[9:0]);
        end
        check_state("flags_cleared");
    endtask

    task automatic test_parity();
        send_frame(8'h1C, 1'b1, 11, 1'b0);
        m_err++;
        check_state("parity_err");
        send_good(8'hF0);
        send_good(8'h1C);
        send_good(8'h1C);
        checks++;
        if (ps2_key[7:0] !== 8'h1C) begin
            failures++;
            $display("FAIL after_parity: got %h expected 1C", ps2_key[7:0]);
        end
        check_state("after_parity");
    endtask

    task automatic test_timeout();
        send_frame(8'h5A, 1'b0, 5, 1'b0);
        repeat (TIMEOUT_CYC + 50) @(negedge clk_sys);
        m_err++;
        check_state("timeout");
        send_good(8'h29);
        check_state("after_timeout");
    endtask

    task automatic test_glitch();
        send_frame(8'h3A, 1'b0, 11, 1'b1);
        model_byte(8'h3A);
        check_state("glitch");
    endtask

    task automatic test_reset_mid();
        send_good(8'hE0);
        send_frame(8'h45, 1'b0, 5, 1'b0);
        @(posedge clk_sys);
        #2 res_n = 1'b0;
        #1;
        checks++;
        if (ps2_key !== 11'h000) begin
            failures++;
            $display("FAIL reset_mid: got %h expected 000", ps2_key);
        end
        model_reset();
        repeat (4) @(negedge clk_sys);
        res_n = 1'b1;
        repeat (HALF) @(negedge clk_sys);
        send_good(8'h45);
        checks++;
        if (ps2_key !== 11'h645) begin
            failures++;
            $display("FAIL reset_mid_45: got %h expected 645", ps2_key);
        end
        check_state("reset_mid_45");
    endtask

    task automatic test_typematic();
        int t0;
        int exp_t;
        t0 = tog_seen;
`ifdef VP_PS2_TYPEMATIC_FILTER_EN
        exp_t = 2;
`else
        exp_t = 4;
`endif
        send_good(8'h1C);
        send_good(8'h1C);
        send_good(8'h1C);
        send_good(8'hF0);
        send_good(8'h1C);
        checks++;
        if (tog_seen - t0 !== exp_t) begin
            failures++;
            $display("FAIL typematic: got %0d toggles expected %0d", tog_seen - t0, exp_t);
        end
        check_state("typematic");
    endtask

    task automatic test_random();
        logic [7:0] b;
        int         k;
        for (int i = 0; i < 20; i++) begin
            k = $urandom_range(0, 9);
            if (k < 2)      b = 8'hE0;
            else if (k < 4) b = 8'hF0;
            else if (k < 5) b = 8'hAA;
            else            b = 8'($urandom_range(1, 8'h83));
            if ($urandom_range(0, 9) == 0) begin
                send_frame(b, 1'b1, 11, 1'b0);
                m_err++;
            end else begin
                send_good(b);
            end
            check_state("random");
        end
    endtask

    initial begin
        test_reset();
        test_press_release();
        test_latency();
        test_ext_break();
        test_parity();
        test_timeout();
        test_glitch();
        test_reset_mid();
        test_typematic();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
